// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external multiplier among NREQ requesters,
// with a registered issue stage, a registered result stage and a tagged, backpressured response.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int A_W = 3,
    parameter int B_W = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int P_W = A_W + B_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VALID,
    output logic [NREQ-1:0]      REQ_READY,
    input  logic [NREQ*A_W-1:0]  REQ_A,
    input  logic [NREQ*B_W-1:0]  REQ_B,
    output logic [A_W-1:0]       MUL_A,
    output logic [B_W-1:0]       MUL_B,
    input  logic [P_W-1:0]       MUL_P,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [ID_W-1:0]      RSP_ID,
    output logic [P_W-1:0]       RSP_P,
    output logic [15:0]          DONE_CNT
);
    logic [ID_W-1:0] ptr, g, s1_id;
    logic any, s1_valid, s1_adv, s2_adv, acc;

    // Scan from the far end so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        g = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (REQ_VALID[(int'(ptr) + k) % NREQ]) begin
                g = ID_W'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

    assign s2_adv = !RSP_VALID || RSP_READY;
    assign s1_adv = !s1_valid || s2_adv;
    assign acc = any && s1_adv && !RST;
    assign REQ_READY = acc ? (NREQ'(1) << g) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
            s1_valid <= 1'b0;
            s1_id <= '0;
            MUL_A <= '0;
            MUL_B <= '0;
            RSP_VALID <= 1'b0;
            RSP_ID <= '0;
            RSP_P <= '0;
            DONE_CNT <= '0;
        end else begin
            // Operand registers only load on accept so the multiplier inputs stay quiet when idle.
            if (acc) begin
                ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
                s1_id <= g;
                MUL_A <= REQ_A[int'(g) * A_W +: A_W];
                MUL_B <= REQ_B[int'(g) * B_W +: B_W];
            end
            if (s1_adv) s1_valid <= acc;
            if (s2_adv) begin
                RSP_VALID <= s1_valid;
                if (s1_valid) begin
                    RSP_ID <= s1_id;
                    RSP_P <= MUL_P;
                end
            end
            if (RSP_VALID && RSP_READY) DONE_CNT <= DONE_CNT + 16'd1;
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and random stimulus checked every cycle against a
// queue-based model (round-robin winner by modulo search, two-slot in-flight buffer).
module tb_mult_share_arbiter;
    localparam int NREQ = 4, A_W = 3, B_W = 4, ID_W = 2, P_W = 7;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [NREQ-1:0] REQ_VALID = '0, REQ_READY;
    logic [NREQ*A_W-1:0] REQ_A = '0;
    logic [NREQ*B_W-1:0] REQ_B = '0;
    logic [A_W-1:0] MUL_A;
    logic [B_W-1:0] MUL_B;
    logic [P_W-1:0] MUL_P;
    logic RSP_VALID, RSP_READY = 1'b1;
    logic [ID_W-1:0] RSP_ID;
    logic [P_W-1:0] RSP_P;
    logic [15:0] DONE_CNT;

    int cmps = 0, errs = 0;

    always #5 CLK = ~CLK;

    // The multiplier that sits beside the arbiter.
    assign MUL_P = P_W'(MUL_A) * P_W'(MUL_B);

    mult_share_arbiter #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_P(MUL_P),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_P(RSP_P),
        .DONE_CNT(DONE_CNT)
    );

    typedef struct {int id; int p; int e;} ent_t;
    ent_t q[$];
    int ptr = 0, edge_n = 0, done = 0;
    logic [NREQ-1:0] cap_rdy;
    logic cap_rv;
    logic [ID_W-1:0] cap_id;
    logic [P_W-1:0] cap_p;
    int prod[4] = '{1, 6, 15, 105};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        REQ_A[i*A_W +: A_W] = A_W'(a);
        REQ_B[i*B_W +: B_W] = B_W'(b);
    endtask

    // One clock: compare at negedge against the model, advance model at posedge, drop accepted requests.
    task automatic step();
        int w, a, b;
        bit cons, acc, rv;
        w = -1; a = 0; b = 0; cons = 0; acc = 0; rv = 0;
        @(negedge CLK);
        cap_rdy = REQ_READY; cap_rv = RSP_VALID; cap_id = RSP_ID; cap_p = RSP_P;
        if (RST) begin
            chk("rst_req_ready", 32'(REQ_READY), 32'(0));
            chk("rst_rsp_valid", 32'(RSP_VALID), 32'(0));
            chk("rst_done_cnt", 32'(DONE_CNT), 32'(0));
        end else begin
            rv = q.size() > 0 && q[0].e < edge_n - 1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && REQ_VALID[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
            cons = rv && RSP_READY;
            acc = w >= 0 && (q.size() - int'(cons)) < 2;
            chk("req_ready", 32'(REQ_READY), acc ? 32'(1 << w) : 32'(0));
            chk("rsp_valid", 32'(RSP_VALID), 32'(rv));
            if (rv) begin
                chk("rsp_id", 32'(RSP_ID), 32'(q[0].id));
                chk("rsp_p", 32'(RSP_P), 32'(q[0].p));
            end
            chk("done_cnt", 32'(DONE_CNT), 32'(done % 65536));
            if (acc) begin
                a = int'(REQ_A[w*A_W +: A_W]);
                b = int'(REQ_B[w*B_W +: B_W]);
            end
        end
        @(posedge CLK);
        if (RST) begin
            q.delete(); ptr = 0; edge_n = 0; done = 0;
        end else begin
            if (cons) begin
                void'(q.pop_front());
                done++;
            end
            if (acc) begin
                q.push_back('{w, a * b, edge_n});
                ptr = (w + 1) % NREQ;
            end
            edge_n++;
        end
        #1;
        for (int i = 0; i < NREQ; i++)
            if (REQ_VALID[i] && cap_rdy[i]) REQ_VALID[i] = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ_VALID = '0;
        RSP_READY = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        // Single op from requester 1.
        set_op(1, 5, 11);
        REQ_VALID[1] = 1'b1;
        step(); chk("t1_grant", 32'(cap_rdy), 32'h2);
        step(); chk("t1_not_yet", 32'(cap_rv), 32'(0));
        step();
        chk("t1_rsp_valid", 32'(cap_rv), 32'(1));
        chk("t1_rsp_id", 32'(cap_id), 32'(1));
        chk("t1_rsp_p", 32'(cap_p), 32'(55));
        chk("t1_done", 32'(DONE_CNT), 32'(1));
        // All four requesting every cycle.
        do_reset();
        set_op(0, 1, 1); set_op(1, 2, 3); set_op(2, 3, 5); set_op(3, 7, 15);
        for (int n = 0; n < 12; n++) begin
            REQ_VALID = 4'hF;
            step();
            chk("t2_grant", 32'(cap_rdy), 32'(1 << (n % 4)));
            if (n >= 2) begin
                chk("t2_rsp_id", 32'(cap_id), 32'((n - 2) % 4));
                chk("t2_rsp_p", 32'(cap_p), 32'(prod[(n - 2) % 4]));
            end
        end
        REQ_VALID = '0;
        repeat (3) step();
        // Pointer wrap.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            REQ_VALID[i] = 1'b1;
            step();
        end
        REQ_VALID = 4'b1001;
        step(); chk("t3_grant3", 32'(cap_rdy), 32'h8);
        step(); chk("t3_grant0", 32'(cap_rdy), 32'h1);
        REQ_VALID = 4'b0011;
        step(); chk("t3_grant1_over_0", 32'(cap_rdy), 32'h2);
        step(); chk("t3_grant0_after", 32'(cap_rdy), 32'h1);
        repeat (3) step();
        // Backpressure with max/zero operands.
        do_reset();
        set_op(0, 7, 15); set_op(1, 0, 15); set_op(2, 3, 4);
        RSP_READY = 1'b0;
        REQ_VALID = 4'b0011;
        step(); step();
        REQ_VALID[2] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_stall_ready", 32'(cap_rdy), 32'(0));
            chk("t4_hold_p", 32'(cap_p), 32'(105));
            chk("t4_hold_id", 32'(cap_id), 32'(0));
        end
        RSP_READY = 1'b1;
        step();
        chk("t4_rel_grant", 32'(cap_rdy), 32'h4);
        chk("t4_rel_p0", 32'(cap_p), 32'(105));
        step(); chk("t4_rel_id1", 32'(cap_id), 32'(1)); chk("t4_rel_p1", 32'(cap_p), 32'(0));
        step(); chk("t4_rel_id2", 32'(cap_id), 32'(2)); chk("t4_rel_p2", 32'(cap_p), 32'(12));
        chk("t4_done", 32'(DONE_CNT), 32'(3));
        step(); chk("t4_drained", 32'(cap_rv), 32'(0));
        // Reset in the middle of operation.
        do_reset();
        set_op(0, 2, 2); set_op(1, 3, 3); set_op(2, 1, 9); set_op(3, 4, 4);
        REQ_VALID[2] = 1'b1;
        repeat (3) step();
        RSP_READY = 1'b0;
        REQ_VALID = 4'b0011;
        step(); step();
        #3;
        RST = 1'b1;
        #1;
        chk("t5_rsp_valid_async", 32'(RSP_VALID), 32'(0));
        chk("t5_done_async", 32'(DONE_CNT), 32'(0));
        REQ_VALID = '0;
        RSP_READY = 1'b1;
        step();
        RST = 1'b0;
        REQ_VALID = 4'b1001;
        step(); chk("t5_ptr_reset", 32'(cap_rdy), 32'h1);
        repeat (4) step();
        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!REQ_VALID[i] && $urandom_range(0, 2) == 0) begin
                    set_op(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
                    REQ_VALID[i] = 1'b1;
                end
            RSP_READY = $urandom_range(0, 3) != 0;
            step();
        end
        REQ_VALID = '0;
        RSP_READY = 1'b1;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
